// File: rtl/pipeline_register_elastic.sv
// Elastic pipeline register between two stages with valid/ready handshake.
// Define PR_SKID_BUFFER_EN to add a skid register and a registered in_ready; otherwise a single main register is used.
module pipeline_register_elastic #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        count
);

`ifdef PR_SKID_BUFFER_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;
`else
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_e;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              push, pop;

`ifdef PR_SKID_BUFFER_EN
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_ready_q;
`endif

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // State and storage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
`ifdef PR_SKID_BUFFER_EN
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
`ifdef PR_SKID_BUFFER_EN
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= (state_d != SKID);
`endif
      end
   end

   // Next-state and storage update; flush wins over push and pop
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
`ifdef PR_SKID_BUFFER_EN
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
`endif
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (push) begin
               state_d     = FULL;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end
            FULL: begin
               if (push && pop) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (pop) begin
                  state_d = EMPTY;
`ifdef PR_SKID_BUFFER_EN
               end else if (push) begin
                  state_d     = SKID;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
`endif
               end
            end
`ifdef PR_SKID_BUFFER_EN
            SKID: if (pop) begin
               state_d     = FULL;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   // Outputs: control bundle reads as a NOP whenever nothing is held
   always_comb begin
      out_valid = (state_q != EMPTY);
      out_data  = main_data_q;
      out_ctrl  = out_valid ? main_ctrl_q : '0;
      case (state_q)
         EMPTY:   count = 2'd0;
         FULL:    count = 2'd1;
         default: count = 2'd2;
      endcase
`ifdef PR_SKID_BUFFER_EN
      in_ready = in_ready_q;
`else
      in_ready = !out_valid || out_ready;
`endif
   end

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Scoreboard bench for pipeline_register_elastic; follows PR_SKID_BUFFER_EN for the capacity-dependent expectations.
module tb_pipeline_register_elastic;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 18;
`ifdef PR_SKID_BUFFER_EN
   localparam int MAXC = 2;
`else
   localparam int MAXC = 1;
`endif

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [1:0]        count;

   int checks = 0;
   int errors = 0;
   logic [DATA_W+CTRL_W-1:0] sb[$];

   pipeline_register_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop before push so an entry never matches itself in its own push cycle
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", {out_data, out_ctrl}, '0);
               if ({out_data, out_ctrl} == '0) begin
                  errors++;
                  $display("FAIL unexpected_output: got output with empty scoreboard expected none");
               end
            end else begin
               check("sb_data_ctrl", {out_data, out_ctrl}, sb.pop_front());
            end
         end
         if (!out_valid) check("bubble_ctrl", out_ctrl, '0);
         if (in_valid && in_ready) sb.push_back({in_data, in_ctrl});
      end
   end

   task automatic fill(input logic [DATA_W-1:0] base);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < MAXC; i++) begin
         in_data = base + DATA_W'(i);
         in_ctrl = 18'h3F000 | 18'(i + 1);
         step();
      end
      in_valid = 1'b0;
      check("fill_count", count, 2'(MAXC));
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      step(); step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      // Single transfer, one-cycle latency
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 64'h0000_0000_DEAD_BEEF; in_ctrl = 18'h2A5A5;
      step();
      in_valid = 1'b0;
      check("lat_out_valid", out_valid, 1);
      check("lat_out_data", out_data, 64'h0000_0000_DEAD_BEEF);
      check("lat_out_ctrl", out_ctrl, 18'h2A5A5);
      check("lat_count", count, 1);
      step();
      check("lat_drained", count, 0);

      // Backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1111; in_ctrl = 18'h00011;
      step();
`ifdef PR_SKID_BUFFER_EN
      check("bp_ready_after_a", in_ready, 1);
      in_data = 64'h2222; in_ctrl = 18'h00022;
      step();
      check("bp_count_ab", count, 2);
      check("bp_ready_after_b", in_ready, 0);
      in_data = 64'h3333; in_ctrl = 18'h00033;
      step();
      check("bp_count_c_blocked", count, 2);
      check("bp_stable_a", out_data, 64'h1111);
      out_ready = 1'b1;
      step();
      check("bp_pop_a_count", count, 1);
      check("bp_main_b", out_data, 64'h2222);
      step();
      check("bp_c_accepted_count", count, 1);
      check("bp_main_c", out_data, 64'h3333);
      in_valid = 1'b0;
      step();
      check("bp_drained", count, 0);
`else
      check("bp_count", count, 1);
      check("bp_in_ready_low", in_ready, 0);
      in_data = 64'h2222; in_ctrl = 18'h00022;
      step(); step();
      check("bp_stable_data", out_data, 64'h1111);
      check("bp_stable_ctrl", out_ctrl, 18'h00011);
      check("bp_count_hold", count, 1);
      out_ready = 1'b1; in_data = 64'h3333; in_ctrl = 18'h00033;
      #1;
      check("bp_in_ready_comb", in_ready, 1);
      step();
      check("bp_swap_count", count, 1);
      check("bp_swap_data", out_data, 64'h3333);
      in_valid = 1'b0;
      step();
      check("bp_drained", count, 0);
`endif

      // Streaming at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = 64'h100 + 64'(i);
         in_ctrl  = 18'(i);
         step();
         check("stream_count", count, 1);
         check("stream_in_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", count, 0);

      // Flush beats pending pop and presented push
      fill(64'hAAAA1);
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      in_data = 64'hFFFF; in_ctrl = 18'h3FFFF;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_out_ctrl", out_ctrl, 0);
      check("flush_count", count, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_data_hold", out_data, 64'hAAAA1);
      flush = 1'b1; in_valid = 1'b1; in_data = 64'hBBBB; in_ctrl = 18'h0BBBB;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_drop_push", out_valid, 0);
      repeat (3) step();

      // Reset mid-transfer
      fill(64'hCCCC1);
      rst = 1'b1; out_ready = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_out_valid", out_valid, 0);
      check("mrst_out_data", out_data, 0);
      check("mrst_count", count, 0);
      check("mrst_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         out_ready = ~out_ready;
         step();
         check("mrst_no_stale", out_valid, 0);
      end

      // Bounded drain of the scoreboard
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipeline_register_elastic.md
PIPELINE_REGISTER_ELASTIC -- requirements
Module: pipeline_register_elastic

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the datapath payload width (e.g. ALU result plus instruction word).
REQ-002 Parameter CTRL_W, default 18, SHALL set the control-bundle width (selects, MEM read/write, RF write enable, ALU op).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 flush  input  1  SHALL discard all held entries (branch/hazard squash).
REQ-006 in_valid  input  1  SHALL mark in_data/in_ctrl as valid from the upstream stage.
REQ-007 in_ready  output  1  SHALL indicate the stage accepts an entry this cycle.
REQ-008 in_data  input  DATA_W  SHALL be the upstream payload.
REQ-009 in_ctrl  input  CTRL_W  SHALL be the upstream control bundle.
REQ-010 out_valid  output  1  SHALL mark out_data/out_ctrl as valid to the downstream stage.
REQ-011 out_ready  input  1  SHALL indicate downstream acceptance (deasserted = downstream stall).
REQ-012 out_data  output  DATA_W  SHALL be the held payload.
REQ-013 out_ctrl  output  CTRL_W  SHALL be the held control bundle.
REQ-014 count  output  2  SHALL report entries held (0..2).

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 Storage SHALL be a main register plus one skid register; FSM states EMPTY (0 held), FULL (main only), SKID (both).
REQ-017 Transitions: EMPTY+push -> FULL; FULL+push+no pop -> SKID; FULL+pop+no push -> EMPTY; FULL+push+pop -> FULL, main loads in_*; SKID+pop -> FULL, skid moves to main; otherwise hold.
REQ-018 in_ready SHALL be a registered signal, 1 in EMPTY and FULL, 0 in SKID; it SHALL NOT depend combinationally on out_ready.
REQ-019 Latency SHALL be one cycle: an entry pushed in EMPTY is on out_* with out_valid=1 the following cycle.
REQ-020 Entries SHALL leave in push order with no loss or duplication; out_data/out_ctrl SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 out_ctrl SHALL be all-zero (bubble/NOP: no MEM write, no RF write) whenever out_valid=0; out_data SHALL hold its last value.
REQ-022 flush SHALL take priority over push and pop: next state EMPTY, count=0, out_valid=0, out_ctrl=0; an entry presented in the flush cycle SHALL be dropped.
REQ-023 count SHALL equal 0/1/2 in EMPTY/FULL/SKID respectively.
REQ-024 in_valid while in_ready=0 SHALL have no effect; upstream keeps the entry.

Reset
REQ-025 On rst=1 at a rising edge: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, count=0, in_ready=1, skid register cleared.
REQ-026 rst SHALL override flush, push and pop; reset asserted mid-transfer SHALL drop all held entries with no out_valid pulse afterwards.

Configuration
REQ-027 Macro PR_SKID_BUFFER_EN SHALL select the storage mode.
REQ-028 With PR_SKID_BUFFER_EN defined: behaviour per REQ-016..REQ-023 (two entries, registered in_ready).
REQ-029 Without it: main register only, no SKID state, count max 1, in_ready = !out_valid || out_ready (combinational); all other requirements unchanged.

Verification
REQ-030 Reset then push data=0x0000_0000_DEAD_BEEF, ctrl=0x2A5A5 with out_ready=1 -> next cycle out_valid=1, out_data=0x...DEADBEEF, out_ctrl=0x2A5A5, count=1.
REQ-031 Push 3 entries A,B,C back-to-back with out_ready=0 (skid enabled) -> A,B accepted, in_ready=0 after B, count=2; release out_ready -> A,B,C emerge in order, one per cycle.
REQ-032 Continuous push and pop 100 sequential values with out_ready=1 -> 100 outputs in order, count stays 1, in_ready never drops.
REQ-033 Fill to count=2, assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, count=0, in_ready=1; flushed-cycle entry never appears.
REQ-034 Assert rst while count=2 and out_ready toggling -> after the edge out_valid=0, out_data=0, count=0; no stale entry emerges later.
REQ-035 Build without PR_SKID_BUFFER_EN, hold out_ready=0 after one push -> in_ready=0, count=1; raise out_ready with in_valid=1 -> same-cycle pop and push, count stays 1.
